// File: rtl/deal_sequencer.sv
// Card deal sequencer: pulls codes from a random source over valid/ready,
// rejects out-of-range and duplicate codes, and packs accepted cards in slot order.
module deal_sequencer #(
  parameter int NUM_CARDS  = 9,
  parameter int CARD_W     = 6,
  parameter int DECK_SIZE  = 52,
  parameter int MAX_REJECT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  output logic                          rng_req,
  input  logic                          rng_valid,
  input  logic [CARD_W-1:0]             rng_card,
  output logic [NUM_CARDS*CARD_W-1:0]   dealt_cards,
  output logic [3:0]                    card_count,
  output logic                          all_cards_dealt,
  output logic                          busy,
  output logic                          err_stuck,
  output logic [7:0]                    reject_total
);

  localparam int CONSEC_W = $clog2(MAX_REJECT + 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE, ERROR} stateT;

  stateT                        stateReg, stateNext;
  logic [DECK_SIZE-1:0]         usedReg;
  logic [DECK_SIZE-1:0]         cardHot;
  logic [NUM_CARDS*CARD_W-1:0]  dealtReg, dealtNext;
  logic [3:0]                   countReg;
  logic [7:0]                   rejTotalReg;
  logic [CONSEC_W-1:0]          consecReg;

  logic inRange, cardFresh, xfer, acceptXfer, rejectXfer, clearDeal;
  logic lastCard, consecFull;

  // One-hot decode of the candidate; only meaningful once the range check passes.
  for (genvar gi = 0; gi < DECK_SIZE; gi++) begin : gHot
    assign cardHot[gi] = (rng_card == CARD_W'(gi));
  end

  assign inRange    = (32'(rng_card) < DECK_SIZE);
  assign cardFresh  = inRange && ((cardHot & usedReg) == '0);
  assign xfer       = (stateReg == DRAW) && rng_valid && !abort;
  assign acceptXfer = xfer && cardFresh;
  assign rejectXfer = xfer && !cardFresh;
  assign clearDeal  = abort || (start && (stateReg != DRAW));
  assign lastCard   = (countReg == 4'(NUM_CARDS - 1));
  assign consecFull = (consecReg == CONSEC_W'(MAX_REJECT - 1));

  for (genvar gi = 0; gi < NUM_CARDS; gi++) begin : gSlot
    assign dealtNext[gi*CARD_W +: CARD_W] =
      clearDeal                             ? '0       :
      (acceptXfer && countReg == 4'(gi))    ? rng_card :
                                              dealtReg[gi*CARD_W +: CARD_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    if (abort) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE:  if (start) stateNext = DRAW;
        // An accept clears the reject run, so completing the deal wins over a stuck source.
        DRAW: begin
          if (acceptXfer && lastCard)       stateNext = DONE;
          else if (rejectXfer && consecFull) stateNext = ERROR;
        end
        DONE:  if (start) stateNext = DRAW;
        ERROR: if (start) stateNext = DRAW;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    rng_req         = (stateReg == DRAW);
    busy            = (stateReg == DRAW);
    all_cards_dealt = (stateReg == DONE);
    err_stuck       = (stateReg == ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dealtReg    <= '0;
      countReg    <= '0;
      usedReg     <= '0;
      rejTotalReg <= '0;
      consecReg   <= '0;
    end else begin
      dealtReg <= dealtNext;
      if (clearDeal) begin
        countReg    <= '0;
        usedReg     <= '0;
        rejTotalReg <= '0;
        consecReg   <= '0;
      end else if (acceptXfer) begin
        countReg  <= countReg + 4'd1;
        usedReg   <= usedReg | cardHot;
        consecReg <= '0;
      end else if (rejectXfer) begin
        if (rejTotalReg != 8'hFF) rejTotalReg <= rejTotalReg + 8'd1;
        consecReg <= consecReg + CONSEC_W'(1);
      end
    end
  end

  assign dealt_cards  = dealtReg;
  assign card_count   = countReg;
  assign reject_total = rejTotalReg;

endmodule

// File: doc/deal_sequencer.md
Name: deal_sequencer

Overview:
- Controls the random card source and fills the 9-card deal vector (2 player, 2 dealer, 5 community) consumed by the game state machine.
- Requests cards one at a time over a valid/ready handshake.
- Rejects out-of-range codes and duplicates using a 52-bit used-card mask, packs accepted cards in slot order, and flags completion, or a stuck source, to the game controller.

Parameters:
- NUM_CARDS, 9, cards per deal.
- CARD_W, 6, bits per card code.
- DECK_SIZE, 52, valid codes are 0..DECK_SIZE-1.
- MAX_REJECT, 64, consecutive rejected codes before error.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  begin a new deal; sampled in IDLE, DONE, ERROR.
- abort  in  1  cancel deal; highest priority after reset.
- rng_req  out  1  ready: sequencer accepts a card this cycle.
- rng_valid  in  1  source presents a card.
- rng_card  in  CARD_W  candidate card code.
- dealt_cards  out  NUM_CARDS*CARD_W  slot i at bits [i*CARD_W+CARD_W-1 : i*CARD_W].
- card_count  out  4  number of accepted cards, 0..NUM_CARDS.
- all_cards_dealt  out  1  high in DONE.
- busy  out  1  high in DRAW.
- err_stuck  out  1  high in ERROR.
- reject_total  out  8  saturating count of rejects in the current deal.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - State goes to IDLE.
  - dealt_cards=0, card_count=0, used mask=0, reject_total=0, consecutive reject counter=0.
  - All 1-bit outputs are 0.
- **States:** IDLE, DRAW, DONE, ERROR (registered). Outputs decode from state: busy=DRAW, rng_req=DRAW, all_cards_dealt=DONE, err_stuck=ERROR.
- **IDLE:**
  - start=1 -> DRAW next cycle.
  - Same edge clears dealt_cards, card_count, used mask, reject_total and the consecutive counter.
- **DRAW, transfer rule:** a transfer occurs on an edge where rng_req=1 and rng_valid=1. At most one card per cycle.
- **DRAW, acceptance test:** combinational on rng_card. Accept iff rng_card < DECK_SIZE and used[rng_card]=0.
- **DRAW, on accept:**
  - Write rng_card into slot card_count.
  - Set used[rng_card]; increment card_count; clear the consecutive counter.
  - If the new card_count == NUM_CARDS -> DONE.
- **DRAW, on reject:**
  - Slot, count and mask are unchanged.
  - reject_total increments, saturating at 255.
  - Consecutive counter increments. When it reaches MAX_REJECT -> ERROR.
- **DRAW, other inputs:**
  - rng_valid=0: hold, no change.
  - start while in DRAW: ignored.
- **Latency:**
  - rng_req rises the cycle after start is accepted.
  - all_cards_dealt rises the cycle after the 9th accepted transfer.
  - Minimum start-to-done is NUM_CARDS+1 cycles with rng_valid held high and no rejects.
- **DONE:**
  - dealt_cards and card_count are held stable.
  - start=1 clears everything and re-enters DRAW, identical to the IDLE start.
- **ERROR:**
  - Held until start (restart, as in IDLE) or abort.
  - Partial dealt_cards and card_count remain visible for debug.
- **abort=1 in any state:**
  - Next state is IDLE; all registers are cleared as on reset.
  - A transfer on the same edge is discarded.
  - abort takes precedence over start.
- **Width rules:**
  - Compare rng_card zero-extended against DECK_SIZE.
  - Codes 52..63 are always rejects.
  - Mask index is used only after the range check passes.
- **Simultaneous events:**
  - An accept that completes the 9th card on the same edge as the consecutive counter would saturate -> DONE wins, since an accept clears the counter.
  - Asynchronous reset during DRAW discards any in-flight card.

Test Plan:
- **Clean deal:** start; rng_valid=1 each cycle with codes 0,1,2,...,8.
  - card_count 9; all_cards_dealt high at cycle 10.
  - Slot 0 = 0 and slot 8 = 8 (bits [53:48] = 6'd8).
  - rng_req low in DONE.
- **Duplicate rejection:** feed 5,5,5,7,...
  - Only the first 5 is stored; slot 1 = 7.
  - reject_total = 2; card_count advances only on unique codes.
- **Out-of-range codes:** feed 52 and 63 mid-deal.
  - Both rejected; mask unchanged.
  - A later 51 is accepted into the next slot.
- **Stuck source:** after 3 accepted cards, feed code 60 for 64 consecutive transfers.
  - err_stuck high the cycle after the 64th reject.
  - card_count stays 3; start then restarts with count 0.
- **Abort / async reset:**
  - abort after 4 cards -> IDLE next cycle; dealt_cards=0, card_count=0.
  - Pulling reset low mid-DRAW clears all outputs immediately, without waiting for a clock edge.
- **Back-to-back deals with stalls:**
  - In DONE, start -> mask cleared; the previous deal's codes are accepted again.
  - Gaps in rng_valid insert no spurious transfers.
